// File: rtl/clk_div_prog.sv
// Programmable clock divider: 50% duty clk_out for any divisor 2..2^DIV_W-1, with
// divisor changes deferred to period boundaries and a clean stop/start on en.
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur,
  output logic             load_ack,
  output logic             div_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_W-1:0] DEF_DIV = DEFAULT_DIV[DIV_W-1:0];

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             q_p_q, q_p_d;
  logic             q_n_q;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             load_ok;
  logic             wrap;
  logic [DIV_W-1:0] half_d;

  assign load_ok = div_load && (div_val >= DIV_W'(2));
  assign wrap    = (cnt_q == div_q - DIV_W'(1));
  // ceil(D/2) without needing an extra carry bit
  assign half_d  = (div_d >> 1) + DIV_W'(div_d[0]);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = 1'b0;
    err_d      = div_load && !load_ok;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) begin
          state_d = RUN;
          if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
          end
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (!en) begin
            state_d = IDLE;
          end else if (pend_vld_q) begin
            div_d      = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A load landing on a boundary only becomes pending for the next one.
    if (load_ok) begin
      pend_d     = div_val;
      pend_vld_d = 1'b1;
    end
    q_p_d = (state_d == RUN) && (cnt_d < half_d);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DEF_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      q_p_q      <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      q_p_q      <= q_p_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  always_ff @(negedge clk_in) begin
    if (!rst_n) q_n_q <= 1'b0;
    else        q_n_q <= q_p_q;
  end

  // Odd divisors trim half a cycle off the high phase via the negedge copy.
  assign clk_out  = q_p_q & (q_n_q | ~div_q[0]);
  assign tick     = (state_q == RUN) && (cnt_q == '0);
  assign div_cur  = div_q;
  assign load_ack = ack_q;
  assign div_err  = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomized bench for clk_div_prog against a half-cycle waveform model.
module tb_clk_div_prog;

  localparam int DIV_W = 8;
  localparam int DEF   = 7;

  logic             clk_in;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] div_cur;
  logic             load_ack;
  logic             div_err;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: running flag, position in period, divisor, pending divisor
  int m_run  = 0;
  int m_k    = 0;
  int m_D    = DEF;
  int m_pv   = 0;
  int m_pend = 0;
  int m_ack  = 0;
  int m_err  = 0;

  clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .div_val (div_val),
    .div_load(div_load),
    .clk_out (clk_out),
    .tick    (tick),
    .div_cur (div_cur),
    .load_ack(load_ack),
    .div_err (div_err)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic apply_pending();
    if (m_pv != 0) begin
      m_D   = m_pend;
      m_pv  = 0;
      m_ack = 1;
    end
  endtask

  task automatic model_update();
    m_ack = 0;
    m_err = 0;
    if (!rst_n) begin
      m_run = 0; m_k = 0; m_D = DEF; m_pv = 0; m_pend = 0;
    end else begin
      m_err = (div_load && int'(div_val) < 2) ? 1 : 0;
      if (m_run == 0) begin
        if (en) begin
          m_run = 1; m_k = 0;
          apply_pending();
        end
      end else if (m_k == m_D - 1) begin
        m_k = 0;
        if (!en) m_run = 0;
        else     apply_pending();
      end else begin
        m_k++;
      end
      if (div_load && int'(div_val) >= 2) begin
        m_pend = int'(div_val);
        m_pv   = 1;
      end
    end
  endtask

  // h counts half-cycles from the period start; the high phase spans D half-cycles.
  function automatic int exp_clk(input int h);
    if (m_run == 0) return 0;
    if (m_D % 2 == 0) return (h < m_D) ? 1 : 0;
    return (h >= 1 && h <= m_D) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk_in);
    model_update();
    #1;
    chk("tick",     tick,     (m_run != 0 && m_k == 0) ? 1 : 0);
    chk("div_cur",  div_cur,  m_D);
    chk("load_ack", load_ack, m_ack);
    chk("div_err",  div_err,  m_err);
    chk("clk_hi_half", clk_out, exp_clk(2 * m_k));
    @(negedge clk_in);
    #1;
    chk("clk_lo_half", clk_out, exp_clk(2 * m_k + 1));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_k(input int kk, input int limit);
    for (int i = 0; i < limit && !(m_run != 0 && m_k == kk); i++) step();
  endtask

  task automatic load(input int v);
    div_load = 1'b1;
    div_val  = DIV_W'(v);
    step();
    div_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;
    steps(3);
    rst_n = 1'b1;
    steps(2);

    // default divisor 7
    en = 1'b1;
    steps(22);

    // load 4 mid-period: old period completes, then 4
    run_until_k(2, 20);
    load(4);
    steps(20);

    // illegal loads
    load(1);
    step();
    load(0);
    steps(10);

    // stop at cnt=1 with D=5, then restart
    load(5);
    for (int i = 0; i < 20 && m_D != 5; i++) step();
    run_until_k(1, 10);
    en = 1'b0;
    steps(12);
    en = 1'b1;
    steps(12);

    // stop cancelled before the wrap
    run_until_k(1, 10);
    en = 1'b0;
    steps(2);
    en = 1'b1;
    steps(10);

    // load landing exactly on a boundary, then back-to-back overwrite
    run_until_k(4, 10);
    load(6);
    load(3);
    steps(20);

    // maximum divisor
    load(255);
    steps(2 * 255 + 20);

    // randomized traffic with small divisors and occasional resets
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      div_load = ($urandom_range(0, 5) == 0);
      div_val  = DIV_W'($urandom_range(0, 9));
      rst_n    = ($urandom_range(0, 79) != 0);
      step();
    end
    div_load = 1'b0;
    rst_n    = 1'b1;
    en       = 1'b1;
    steps(5);

    // reset during a high phase
    run_until_k(1, 300);
    rst_n = 1'b0;
    step();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_div_cur", div_cur, DEF);
    step();
    rst_n = 1'b1;
    steps(16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
